line_buffer_prog: RTL and testbench

Multi-tap programmable-length delay line for the camera pixel pipeline. Each tap delays the incoming pixel stream by a further `size` accepted samples. With `size` set to the active line width, the taps present vertically aligned pixels from consecutive image lines to downstream window or filter logic. Line length is run-time programmable up to `MEMORY_SIZE`, and each tap reports when it holds genuine data.

---
 rtl/line_buffer_prog.sv | 96 +++++++++
 tb/tb_line_buffer_prog.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/line_buffer_prog.sv
// Multi-tap programmable-length line buffer for the pixel pipeline.
// Each tap delays accepted samples by a further size_reg entries.
module line_buffer_prog #(
  parameter int MEMORY_WIDTH = 8,
  parameter int MEMORY_SIZE  = 1024,
  parameter int TAPS         = 2,
  parameter int SIZE_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         load,
  input  logic [SIZE_WIDTH-1:0]        size,
  input  logic [MEMORY_WIDTH-1:0]      data_in,
  output logic [TAPS*MEMORY_WIDTH-1:0] data_out,
  output logic [TAPS-1:0]              tap_valid,
  output logic                         primed
);

  localparam int W  = MEMORY_WIDTH;
  localparam int PW = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam int SW = $clog2(MEMORY_SIZE + 1);
  localparam int FW = $clog2(TAPS * MEMORY_SIZE + 1);

  logic [SW-1:0] size_reg;
  logic [SW-1:0] size_clamp;
  logic [PW-1:0] ptr;
  logic          ptr_last;
  logic [FW-1:0] fill;
  logic [FW-1:0] fill_max;
  logic [FW-1:0] thr [TAPS];
  logic [TAPS-1:0] tap_hit;
  logic          restart;
  logic          accept;

  logic [W-1:0]            mem [TAPS][MEMORY_SIZE];
  logic [TAPS-1:0][W-1:0]  rdata;
  logic [TAPS-1:0][W-1:0]  wdata;

  assign restart = reset | load;
  assign accept  = enable & ~restart;
  assign primed  = tap_valid[TAPS-1];

  always_comb begin
    size_clamp = SW'(size);
    if (size == '0)
      size_clamp = SW'(1);
    else if (32'(size) > 32'(MEMORY_SIZE))
      size_clamp = SW'(MEMORY_SIZE);
  end

  assign ptr_last = (SW'(ptr) == size_reg - SW'(1));

  // fill counts edges before the current one, so fill >= (k+1)*size
  // on the accepting edge means this edge lands a real sample on tap k
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      thr[k]     = FW'((k + 1) * int'(size_reg));
      tap_hit[k] = (fill >= thr[k]);
    end
    fill_max = thr[TAPS-1];
  end

  always_comb begin
    for (int k = 0; k < TAPS; k++)
      rdata[k] = mem[k][ptr];
    wdata[0] = data_in;
    for (int k = 1; k < TAPS; k++)
      wdata[k] = rdata[k-1];
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < TAPS; k++)
        mem[k][ptr] <= wdata[k];
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      size_reg  <= size_clamp;
      ptr       <= '0;
      fill      <= '0;
      data_out  <= '0;
      tap_valid <= '0;
    end else if (enable) begin
      ptr <= ptr_last ? '0 : ptr + PW'(1);
      if (fill < fill_max)
        fill <= fill + FW'(1);
      tap_valid <= tap_hit;
      for (int k = 0; k < TAPS; k++)
        data_out[k*W +: W] <= tap_hit[k] ? rdata[k] : '0;
    end
  end

endmodule

// File: tb/tb_line_buffer_prog.sv
// Randomized bench for line_buffer_prog against a queue-based
// model of the delayed-sample contract.
module tb_line_buffer_prog;

  localparam int W  = 8;
  localparam int MS = 1024;
  localparam int T  = 3;
  localparam int SZ = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b0;
  logic            load = 1'b0;
  logic [SZ-1:0]   size = '0;
  logic [W-1:0]    data_in = '0;
  logic [T*W-1:0]  data_out;
  logic [T-1:0]    tap_valid;
  logic            primed;

  line_buffer_prog #(
    .MEMORY_WIDTH(W),
    .MEMORY_SIZE (MS),
    .TAPS        (T),
    .SIZE_WIDTH  (SZ)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .load     (load),
    .size     (size),
    .data_in  (data_in),
    .data_out (data_out),
    .tap_valid(tap_valid),
    .primed   (primed)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int s_mod = 1;
  int hist[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clampf(int sz);
    if (sz == 0) return 1;
    if (sz > MS) return MS;
    return sz;
  endfunction

  task automatic step(bit en, bit ld, bit rs, int sz, int d);
    logic [T*W-1:0] e_out;
    logic [T-1:0]   e_vld;
    int n;
    enable  = en;
    load    = ld;
    reset   = rs;
    size    = SZ'(sz);
    data_in = W'(d);
    @(posedge clk);
    if (rs || ld) begin
      s_mod = clampf(sz);
      hist.delete();
    end else if (en) begin
      hist.push_back(d & 255);
    end
    #1;
    e_out = '0;
    e_vld = '0;
    n = hist.size();
    for (int k = 0; k < T; k++) begin
      if (n - 1 >= (k + 1) * s_mod) begin
        e_out[k*W +: W] = W'(hist[n - 1 - (k + 1) * s_mod]);
        e_vld[k] = 1'b1;
      end
    end
    chk("data_out", 64'(data_out), 64'(e_out));
    chk("tap_valid", 64'(tap_valid), 64'(e_vld));
    chk("primed", 64'(primed), 64'(e_vld[T-1]));
  endtask

  initial begin
    int acc;

    // ramp, size 64, continuous enable
    step(1, 0, 1, 64, 0);
    chk("reset_out", 64'(data_out), 64'(0));
    for (int i = 0; i < 200; i++) begin
      step(1, 0, 0, 64, i);
      if (i == 63) chk("pre_tap0", 64'(tap_valid), 64'(0));
      if (i == 64) chk("edge64_vld", 64'(tap_valid), 64'(3'b001));
      if (i == 127) chk("pre_tap1", 64'(tap_valid), 64'(3'b001));
      if (i == 128) chk("edge128", 64'(data_out[15:0]), 64'(16'h0040));
      if (i == 192) chk("edge192", 64'(data_out), 64'(24'h004080));
    end

    // alternating enable
    step(1, 0, 1, 64, 0);
    acc = 0;
    for (int c = 0; c < 400; c++) begin
      if (c % 2 == 0) begin
        step(1, 0, 0, 64, acc);
        acc++;
      end else begin
        step(0, 0, 0, 64, $urandom_range(0, 255));
      end
      if (c == 126) chk("alt_pre", 64'(tap_valid[0]), 64'(0));
      if (c == 128) chk("alt_first", 64'(tap_valid[0]), 64'(1));
    end

    // random enable and data
    step(0, 0, 1, 37, 0);
    for (int c = 0; c < 300; c++)
      step(1'($urandom_range(0, 1)), 0, 0, 37, $urandom_range(0, 255));

    // size 0 behaves as 1
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 50; i++)
      step(1, 0, 0, 0, $urandom_range(0, 255));

    // oversize clamps to MEMORY_SIZE
    step(0, 1, 0, 2000, 0);
    for (int i = 0; i < 1100; i++) begin
      step(1, 0, 0, 2000, $urandom_range(0, 255));
      if (i == 1023) chk("clamp_pre", 64'(tap_valid[0]), 64'(0));
      if (i == 1024) chk("clamp_first", 64'(tap_valid[0]), 64'(1));
    end

    // mid-stream load with enable on the same edge
    step(1, 0, 1, 64, 0);
    for (int i = 0; i < 100; i++)
      step(1, 0, 0, 64, $urandom_range(0, 255));
    step(1, 1, 0, 16, 8'hAA);
    chk("load_out", 64'(data_out), 64'(0));
    chk("load_vld", 64'(tap_valid), 64'(0));
    for (int i = 0; i < 60; i++)
      step(1, 0, 0, 16, $urandom_range(0, 255));

    // reset after priming, size input jitter without load
    step(1, 0, 1, 16, 0);
    for (int i = 0; i < 60; i++)
      step(1, 0, 0, 16, $urandom_range(1, 255));
    chk("primed_before", 64'(primed), 64'(1));
    step(1, 0, 1, 16, 8'h55);
    chk("rst_out", 64'(data_out), 64'(0));
    chk("rst_primed", 64'(primed), 64'(0));
    for (int i = 0; i < 60; i++)
      step(1, 0, 0, $urandom_range(1, 100), $urandom_range(0, 255));

    // full-depth ramp across pointer wrap
    step(1, 0, 1, MS, 0);
    for (int i = 0; i < 3000; i++)
      step(1, 0, 0, MS, i);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
